// File: rtl/tag_reservation_station_pkg.sv
// Shared types for the tag reservation station: operand, dispatch and issue
// payloads plus opcode constants.
package my_package;

    localparam int RS_TAG_W  = 5;
    localparam int RS_DATA_W = 32;
    localparam int RS_OP_W   = 3;
    localparam int RS_FU_W   = 2;

    typedef logic [RS_OP_W-1:0] rs_op_t;

    localparam rs_op_t OP_R  = 3'd0;
    localparam rs_op_t OP_I  = 3'd1;
    localparam rs_op_t OP_LW = 3'd2;
    localparam rs_op_t OP_SW = 3'd3;

    typedef struct packed {
        logic                 rdy;
        logic [RS_TAG_W-1:0]  tag;
        logic [RS_DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        rs_op_t               op;
        logic [RS_FU_W-1:0]   fu;
        logic [RS_TAG_W-1:0]  dest;
        rs_src_t              src1;
        rs_src_t              src2;
        logic [RS_DATA_W-1:0] imm;
    } rs_disp_t;

    typedef struct packed {
        rs_op_t               op;
        logic [RS_TAG_W-1:0]  dest;
        logic [RS_DATA_W-1:0] src1;
        logic [RS_DATA_W-1:0] src2;
        logic [RS_DATA_W-1:0] imm;
    } rs_issue_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-first picker: grants the requester that no other requester is older than.
// age[j][i] = 1 means entry j is older than entry i.
module rs_oldest_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            req,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            gnt
);

    always_comb begin
        gnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            gnt[i] = req[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && req[j] && age[j][i]) gnt[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tag_reservation_station.sv
// Unified reservation station: multi-lane dispatch, CDB wakeup, and per-FU
// oldest-ready issue selected through an age matrix.
module tag_reservation_station
    import my_package::*;
#(
    parameter int DEPTH   = 16,
    parameter int DISP_W  = 2,
    parameter int NUM_FU  = 3,
    parameter int NUM_CDB = 3,
    parameter int TAG_W   = RS_TAG_W,
    parameter int DATA_W  = RS_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [DISP_W-1:0]                disp_valid,
    input  rs_disp_t [DISP_W-1:0]            disp_entry,
    output logic                             disp_ready,
    input  logic [NUM_CDB-1:0]               cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB-1:0][DATA_W-1:0]   cdb_data,
    output logic [NUM_FU-1:0]                issue_valid,
    input  logic [NUM_FU-1:0]                issue_ready,
    output rs_issue_t [NUM_FU-1:0]           issue_entry,
    output logic [CNT_W-1:0]                 count
);

    logic [DEPTH-1:0]              valid_q, valid_d;
    rs_disp_t [DEPTH-1:0]          ent_q, ent_d;
    logic [DEPTH-1:0][DEPTH-1:0]   age_q, age_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [NUM_FU-1:0][DEPTH-1:0]  req, gnt;
    logic [DEPTH-1:0]              taken;
    logic [CNT_W-1:0]              n_acc, n_iss;
    logic                          found;
    logic [DISP_W-1:0]             bad_fu;

    // Lowest CDB index wins: scan high to low so the last hit is the lowest.
    function automatic rs_src_t wake(input rs_src_t s);
        rs_src_t r;
        r = s;
        if (!s.rdy) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c] == s.tag) begin
                    r.rdy = 1'b1;
                    r.val = cdb_data[c];
                end
            end
        end
        return r;
    endfunction

    assign disp_ready = (DEPTH - int'(count_q)) >= DISP_W;
    assign count      = count_q;

    always_comb begin
        req = '0;
        for (int f = 0; f < NUM_FU; f++)
            for (int i = 0; i < DEPTH; i++)
                req[f][i] = valid_q[i] && ent_q[i].src1.rdy && ent_q[i].src2.rdy
                            && int'(ent_q[i].fu) == f;
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        rs_oldest_select #(.DEPTH(DEPTH)) u_sel (
            .req (req[f]),
            .age (age_q),
            .gnt (gnt[f])
        );
    end

    always_comb begin
        issue_valid = '0;
        issue_entry = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            issue_valid[f] = (|req[f]) && !flush;
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[f][i]) begin
                    issue_entry[f].op   = ent_q[i].op;
                    issue_entry[f].dest = ent_q[i].dest;
                    issue_entry[f].src1 = ent_q[i].src1.val;
                    issue_entry[f].src2 = ent_q[i].src2.val;
                    issue_entry[f].imm  = ent_q[i].imm;
                end
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        age_d   = age_q;
        taken   = '0;
        found   = 1'b0;
        n_acc   = '0;
        n_iss   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                ent_d[i].src1 = wake(ent_q[i].src1);
                ent_d[i].src2 = wake(ent_q[i].src2);
            end
        end
        for (int f = 0; f < NUM_FU; f++) begin
            if (issue_valid[f] && issue_ready[f]) begin
                valid_d = valid_d & ~gnt[f];
                n_iss   = n_iss + CNT_W'(1);
            end
        end
        // Free slots come from registered valid only, so a slot issued this
        // cycle cannot be refilled until the next one.
        if (disp_ready && !flush) begin
            for (int l = 0; l < DISP_W; l++) begin
                if (disp_valid[l]) begin
                    found = 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (!found && !valid_q[i] && !taken[i]) begin
                            found         = 1'b1;
                            taken[i]      = 1'b1;
                            valid_d[i]    = 1'b1;
                            ent_d[i]      = disp_entry[l];
                            ent_d[i].src1 = wake(disp_entry[l].src1);
                            ent_d[i].src2 = wake(disp_entry[l].src2);
                            age_d[i]      = '0;
                            for (int j = 0; j < DEPTH; j++)
                                if (j != i) age_d[j][i] = 1'b1;
                        end
                    end
                    n_acc = n_acc + CNT_W'(1);
                end
            end
        end
        count_d = count_q + n_acc - n_iss;
        if (flush) begin
            valid_d = '0;
            age_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            age_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        bad_fu = '0;
        for (int l = 0; l < DISP_W; l++)
            bad_fu[l] = disp_valid[l] && int'(disp_entry[l].fu) >= NUM_FU;
    end

    // An out-of-range fu is stored but can never issue.
    a_fu_range: assert property (@(posedge clk) disable iff (rst)
        !(disp_ready && !flush && (|bad_fu)));

endmodule

// File: tb/tb_tag_reservation_station.sv
// Scoreboard bench: expected issues are queued as stimulus is driven and
// popped as the station hands them to a functional unit.
module tb_tag_reservation_station;
    import my_package::*;

    localparam int DEPTH = 16, DISP_W = 2, NUM_FU = 3, NUM_CDB = 3;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0] fu;
        rs_issue_t  iss;
    } exp_t;

    logic                               clk, rst, flush;
    logic [DISP_W-1:0]                  disp_valid;
    rs_disp_t [DISP_W-1:0]              disp_entry;
    logic                               disp_ready;
    logic [NUM_CDB-1:0]                 cdb_valid;
    logic [NUM_CDB-1:0][RS_TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB-1:0][RS_DATA_W-1:0]  cdb_data;
    logic [NUM_FU-1:0]                  issue_valid, issue_ready;
    rs_issue_t [NUM_FU-1:0]             issue_entry;
    logic [CNT_W-1:0]                   count;

    int   n_chk = 0, n_fail = 0;
    exp_t exp_q[$];

    tag_reservation_station #(
        .DEPTH(DEPTH), .DISP_W(DISP_W), .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_entry(disp_entry), .disp_ready(disp_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_entry(issue_entry),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] imm_of(input logic [4:0] dest);
        return {27'h0, dest} ^ 32'hA5A5_0000;
    endfunction

    function automatic rs_disp_t mk(input logic [4:0] dest, input logic [1:0] fu,
                                    input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                                    input logic r2, input logic [4:0] t2, input logic [31:0] v2);
        rs_disp_t e;
        e.op       = OP_R;
        e.fu       = fu;
        e.dest     = dest;
        e.src1.rdy = r1; e.src1.tag = t1; e.src1.val = v1;
        e.src2.rdy = r2; e.src2.tag = t2; e.src2.val = v2;
        e.imm      = imm_of(dest);
        return e;
    endfunction

    function automatic exp_t ex(input logic [1:0] fu, input logic [4:0] dest,
                                input logic [31:0] s1, input logic [31:0] s2);
        exp_t x;
        x.fu       = fu;
        x.iss.op   = OP_R;
        x.iss.dest = dest;
        x.iss.src1 = s1;
        x.iss.src2 = s2;
        x.iss.imm  = imm_of(dest);
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input int lane, input rs_disp_t e);
        disp_valid[lane] = 1'b1;
        disp_entry[lane] = e;
    endtask

    task automatic cdb(input int c, input logic [4:0] t, input logic [31:0] d);
        cdb_valid[c] = 1'b1;
        cdb_tag[c]   = t;
        cdb_data[c]  = d;
    endtask

    task automatic clr();
        disp_valid = '0;
        cdb_valid  = '0;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (issue_valid[f] && issue_ready[f]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexp_issue", 64'(issue_entry[f].dest), 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("iss_fu",   64'(f), 64'(e.fu));
                        chk("iss_dest", 64'(issue_entry[f].dest), 64'(e.iss.dest));
                        chk("iss_src1", 64'(issue_entry[f].src1), 64'(e.iss.src1));
                        chk("iss_src2", 64'(issue_entry[f].src2), 64'(e.iss.src2));
                        chk("iss_imm",  64'(issue_entry[f].imm),  64'(e.iss.imm));
                        chk("iss_op",   64'(issue_entry[f].op),   64'(e.iss.op));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = '0; disp_entry = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 64'(count), 0);
        chk("rst_drdy",  64'(disp_ready), 1);
        chk("rst_ivld",  64'(issue_valid), 0);

        // Two ready ADDs, drained one per cycle in lane order
        issue_ready = '1;
        disp(0, mk(1, 0, 1, 0, 32'h10, 1, 0, 32'h20));
        disp(1, mk(2, 0, 1, 0, 32'h11, 1, 0, 32'h21));
        exp_q.push_back(ex(0, 1, 32'h10, 32'h20));
        exp_q.push_back(ex(0, 2, 32'h11, 32'h21));
        tick(); clr();
        chk("t1_cnt2", 64'(count), 2);
        chk("t1_vld",  64'(issue_valid[0]), 1);
        chk("t1_first", 64'(issue_entry[0].dest), 1);
        tick();
        chk("t1_cnt1", 64'(count), 1);
        chk("t1_second", 64'(issue_entry[0].dest), 2);
        tick();
        chk("t1_cnt0", 64'(count), 0);
        chk("t1_idle", 64'(issue_valid), 0);

        // Wakeup two cycles after dispatch
        disp(0, mk(3, 0, 0, 7, 0, 1, 0, 32'h2));
        exp_q.push_back(ex(0, 3, 32'h55, 32'h2));
        tick(); clr();
        chk("t2_wait0", 64'(issue_valid), 0);
        tick();
        chk("t2_wait1", 64'(issue_valid), 0);
        cdb(0, 7, 32'h55);
        tick(); clr();
        chk("t2_vld",  64'(issue_valid[0]), 1);
        chk("t2_src1", 64'(issue_entry[0].src1), 32'h55);
        tick();
        chk("t2_cnt0", 64'(count), 0);

        // Capture on the dispatch cycle itself
        disp(0, mk(4, 0, 1, 0, 32'h1, 0, 9, 0));
        cdb(1, 9, 32'hAB);
        cdb(0, 5, 32'hDEAD);
        exp_q.push_back(ex(0, 4, 32'h1, 32'hAB));
        tick(); clr();
        chk("t3_vld",  64'(issue_valid[0]), 1);
        chk("t3_src2", 64'(issue_entry[0].src2), 32'hAB);
        tick();

        // Same tag on two CDBs: lowest index wins
        disp(0, mk(6, 0, 0, 10, 0, 1, 0, 32'h3));
        exp_q.push_back(ex(0, 6, 32'h11, 32'h3));
        tick(); clr();
        cdb(0, 10, 32'h11);
        cdb(2, 10, 32'h22);
        tick(); clr();
        chk("t3b_src1", 64'(issue_entry[0].src1), 32'h11);
        tick();

        // Fill to DEPTH with non-ready entries
        for (int k = 0; k < DEPTH / 2; k++) begin
            chk("t4_drdy_fill", 64'(disp_ready), 1);
            disp(0, mk(5'(2*k),   0, 0, 5'(16+2*k),   0, 1, 0, 32'(2*k)));
            disp(1, mk(5'(2*k+1), 0, 0, 5'(16+2*k+1), 0, 1, 0, 32'(2*k+1)));
            tick(); clr();
        end
        chk("t4_full_cnt",  64'(count), 16);
        chk("t4_full_drdy", 64'(disp_ready), 0);
        disp(0, mk(30, 0, 0, 30, 0, 1, 0, 0));
        disp(1, mk(31, 0, 0, 30, 0, 1, 0, 0));
        tick(); clr();
        chk("t4_full_ignored", 64'(count), 16);
        cdb(0, 16, 32'h100);
        exp_q.push_back(ex(0, 0, 32'h100, 32'h0));
        tick(); clr();
        chk("t4_wake_vld", 64'(issue_valid[0]), 1);
        tick();
        chk("t4_cnt15",  64'(count), 15);
        chk("t4_drdy15", 64'(disp_ready), 0);
        cdb(0, 17, 32'h101);
        exp_q.push_back(ex(0, 1, 32'h101, 32'h1));
        tick(); clr();
        tick();
        chk("t4_cnt14",  64'(count), 14);
        chk("t4_drdy14", 64'(disp_ready), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_cnt", 64'(count), 0);

        // Hold under backpressure, then drain by age (slot 0 is reused by the youngest)
        issue_ready = 3'b101;
        disp(0, mk(30, 2, 1, 0, 32'h5, 1, 0, 32'h6));
        disp(1, mk(1, 1, 1, 0, 32'h31, 1, 0, 32'h41));
        exp_q.push_back(ex(2, 30, 32'h5, 32'h6));
        exp_q.push_back(ex(1, 1, 32'h31, 32'h41));
        exp_q.push_back(ex(1, 2, 32'h32, 32'h42));
        exp_q.push_back(ex(1, 3, 32'h33, 32'h43));
        tick(); clr();
        disp(0, mk(2, 1, 1, 0, 32'h32, 1, 0, 32'h42));
        tick(); clr();
        disp(1, mk(3, 1, 1, 0, 32'h33, 1, 0, 32'h43));
        tick(); clr();
        chk("t5_cnt3", 64'(count), 3);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_vld",  64'(issue_valid[1]), 1);
            chk("t5_hold_dest", 64'(issue_entry[1].dest), 1);
            tick();
        end
        issue_ready = '1;
        chk("t5_drain1", 64'(issue_entry[1].dest), 1);
        tick();
        chk("t5_drain2", 64'(issue_entry[1].dest), 2);
        chk("t5_cnt2",   64'(count), 2);
        tick();
        chk("t5_drain3", 64'(issue_entry[1].dest), 3);
        tick();
        chk("t5_cnt0", 64'(count), 0);

        // Flush with 6 entries and a concurrent dispatch
        issue_ready = '0;
        for (int k = 0; k < 3; k++) begin
            disp(0, mk(5'(10+2*k), 0, 1, 0, 32'h1, 1, 0, 32'h2));
            disp(1, mk(5'(11+2*k), 0, 1, 0, 32'h1, 1, 0, 32'h2));
            tick(); clr();
        end
        chk("t6_cnt6", 64'(count), 6);
        chk("t6_vld",  64'(issue_valid[0]), 1);
        flush = 1'b1;
        issue_ready = '1;
        disp(0, mk(20, 0, 1, 0, 32'h1, 1, 0, 32'h2));
        disp(1, mk(21, 0, 1, 0, 32'h1, 1, 0, 32'h2));
        #1;
        chk("t6_flush_ivld", 64'(issue_valid), 0);
        tick();
        flush = 1'b0; clr();
        chk("t6_cnt0", 64'(count), 0);
        chk("t6_ivld", 64'(issue_valid), 0);
        chk("t6_drdy", 64'(disp_ready), 1);
        tick();
        chk("t6_nodisp", 64'(issue_valid), 0);

        // Reset in the middle of a wakeup
        issue_ready = 3'b110;
        disp(0, mk(12, 0, 1, 0, 32'h1, 1, 0, 32'h2));
        disp(1, mk(13, 0, 0, 12, 0, 1, 0, 32'h3));
        tick(); clr();
        chk("t7_cnt2", 64'(count), 2);
        chk("t7_vld",  64'(issue_valid[0]), 1);
        rst = 1'b1;
        cdb(0, 12, 32'h77);
        tick();
        rst = 1'b0; clr();
        issue_ready = '1;
        chk("t7_cnt0", 64'(count), 0);
        chk("t7_drdy", 64'(disp_ready), 1);
        chk("t7_ivld", 64'(issue_valid), 0);
        tick();
        chk("t7_ivld2", 64'(issue_valid), 0);

        chk("sb_empty", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
